// File: rtl/pipe_wb_regfile.sv
// Write-back stage and 32-entry general register file (r0 hard-wired to zero),
// with a committed-write counter. Define REGFILE_BYPASS_EN for write-through reads.
module pipe_wb_regfile #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [4:0]        wrn,
  input  logic [DATA_W-1:0] walu,
  input  logic [DATA_W-1:0] wmo,
  input  logic [4:0]        rna,
  input  logic [4:0]        rnb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wdi,
  output logic              wcommit,
  output logic [31:0]       wb_count
);

  logic [DATA_W-1:0] rf [1:31];
  logic [31:0]       wb_count_q;
  logic [DATA_W-1:0] rda;
  logic [DATA_W-1:0] rdb;

  assign wdi     = wm2reg ? wmo : walu;
  assign wcommit = wwreg & (wrn != 5'd0) & resetn;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 1; i < 32; i++) begin
        rf[i] <= RESET_VAL;
      end
    end else if (wcommit) begin
      rf[wrn] <= wdi;
    end
  end

  // Counter wraps naturally at 2^32; writes aimed at r0 never reach wcommit.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wb_count_q <= '0;
    end else if (wcommit) begin
      wb_count_q <= wb_count_q + 32'd1;
    end
  end

  assign wb_count = wb_count_q;

  always_comb begin
    rda = '0;
    rdb = '0;
    if (rna != 5'd0) rda = rf[rna];
    if (rnb != 5'd0) rdb = rf[rnb];
  end

`ifdef REGFILE_BYPASS_EN
  // wcommit already excludes r0, so a bypass never overrides the zero read.
  always_comb begin
    qa = rda;
    qb = rdb;
    if (wcommit && (rna == wrn)) qa = wdi;
    if (wcommit && (rnb == wrn)) qb = wdi;
  end
`else
  always_comb begin
    qa = rda;
    qb = rdb;
  end
`endif

endmodule
